// File: rtl/alu_pkg.sv
// Shared ALU definitions: aluController encodings used by the ALU decoder and
// the execution unit, plus the execution-unit FSM state type.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_MUL = 4'b0010;
  localparam logic [3:0] ALU_SLT = 4'b0011;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

endpackage

// File: rtl/alu_iter_mul.sv
// Iterative shift-add multiplier retiring MUL_BITS multiplier bits per cycle.
// done is combinational in the final iteration; product is valid alongside it.
module alu_iter_mul #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned MUL_CYC = WIDTH / MUL_BITS;
  localparam int unsigned CNT_W   = $clog2(MUL_CYC + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_CYC - 1);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(MUL_CYC);

  logic             busy;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] partial;
  logic [WIDTH-1:0] acc_nxt;

  always_comb begin
    partial = '0;
    for (int unsigned j = 0; j < MUL_BITS; j++) begin
      if (mplier[j]) partial = partial + (mcand << j);
    end
    acc_nxt = acc + partial;
  end

  // The last iteration's sum is forwarded directly so the result lands in the
  // top's output register on the same edge the counter reaches terminal count.
  assign done    = busy & (cnt == LAST) & ~abort;
  assign product = acc_nxt;

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (busy) begin
      acc    <= acc_nxt;
      mcand  <= mcand << MUL_BITS;
      mplier <= mplier >> MUL_BITS;
      if (cnt == LAST) begin
        busy <= 1'b0;
        cnt  <= TERM;
      end else if (cnt != TERM) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage execution unit: single-cycle add/sub/slt, iterative mul that stalls
// upstream issue while in flight. Results and zero flag are registered.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluController,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             flush,
  output logic             stall,
  output logic             out_valid,
  output logic [WIDTH-1:0] aluResult,
  output logic             zero
);

  state_t           state, state_nxt;
  logic             is_mul;
  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] sc_result;

  assign is_mul    = (aluController == ALU_MUL);
  assign accept    = in_valid & in_ready & ~flush;
  assign mul_start = accept & is_mul;

  always_comb begin
    case (aluController)
      ALU_SUB: sc_result = srcA - srcB;
      ALU_SLT: sc_result = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      default: sc_result = srcA + srcB;
    endcase
  end

  always_comb begin
    state_nxt = state;
    in_ready  = (state == S_IDLE) & ~rst;
    stall     = (state == S_MUL) | (in_valid & in_ready & is_mul);
    case (state)
      S_IDLE:  if (mul_start) state_nxt = S_MUL;
      S_MUL:   if (flush || mul_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  alu_iter_mul #(
    .WIDTH    (WIDTH),
    .MUL_BITS (MUL_BITS)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .abort   (flush),
    .a       (srcA),
    .b       (srcB),
    .done    (mul_done),
    .product (mul_product)
  );

  // accept only fires in IDLE and mul_done only in MUL, so the two result
  // sources can never collide on out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      aluResult <= '0;
      zero      <= 1'b1;
    end else begin
      state     <= state_nxt;
      out_valid <= 1'b0;
      if (accept && !is_mul) begin
        out_valid <= 1'b1;
        aluResult <= sc_result;
        zero      <= (sc_result == '0);
      end else if (mul_done) begin
        out_valid <= 1'b1;
        aluResult <= mul_product;
        zero      <= (mul_product == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit (WIDTH=32, MUL_BITS=1) with hand-computed
// expected values checked by immediate assertions.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  aluController;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        flush;
  logic        stall;
  logic        out_valid;
  logic [31:0] aluResult;
  logic        zero;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(
    .WIDTH    (32),
    .MUL_BITS (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .aluController (aluController),
    .srcA          (srcA),
    .srcB          (srcB),
    .flush         (flush),
    .stall         (stall),
    .out_valid     (out_valid),
    .aluResult     (aluResult),
    .zero          (zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid      = 1'b1;
    aluController = op;
    srcA          = a;
    srcB          = b;
  endtask

  task automatic idle_in();
    in_valid      = 1'b0;
    aluController = 4'b0000;
    srcA          = '0;
    srcB          = '0;
  endtask

  task automatic mul_expect(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp);
    int lat;
    issue(4'b0010, a, b);
    tick();
    idle_in();
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, 33);
    chk({tag, "_result"}, aluResult, exp);
    chk({tag, "_zero"}, {31'b0, zero}, {31'b0, exp == 32'h0});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    rst   = 1'b1;
    flush = 1'b0;
    idle_in();
    tick();
    tick();
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", aluResult, 32'h0);
    chk("rst_zero", {31'b0, zero}, 32'd1);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // add then sub back-to-back
    issue(4'b0000, 32'd7, 32'd5);
    tick();
    chk("add_valid", {31'b0, out_valid}, 32'd1);
    chk("add_result", aluResult, 32'd12);
    chk("add_zero", {31'b0, zero}, 32'd0);
    issue(4'b0001, 32'd5, 32'd7);
    tick();
    chk("sub_valid", {31'b0, out_valid}, 32'd1);
    chk("sub_result", aluResult, 32'hFFFF_FFFE);
    chk("sub_zero", {31'b0, zero}, 32'd0);
    idle_in();
    tick();
    chk("idle_valid", {31'b0, out_valid}, 32'd0);
    chk("idle_hold", aluResult, 32'hFFFF_FFFE);

    issue(4'b0011, 32'hFFFF_FFFF, 32'd1);
    tick();
    chk("slt_neg_result", aluResult, 32'd1);
    chk("slt_neg_zero", {31'b0, zero}, 32'd0);
    issue(4'b0011, 32'd1, 32'hFFFF_FFFF);
    tick();
    chk("slt_pos_result", aluResult, 32'd0);
    chk("slt_pos_zero", {31'b0, zero}, 32'd1);
    issue(4'b0001, 32'd9, 32'd9);
    tick();
    chk("sub_eq_result", aluResult, 32'd0);
    chk("sub_eq_zero", {31'b0, zero}, 32'd1);
    issue(4'b1010, 32'd3, 32'd4);
    tick();
    chk("unk_valid", {31'b0, out_valid}, 32'd1);
    chk("unk_result", aluResult, 32'd7);
    issue(4'b1111, 32'hFFFF_FFFF, 32'd2);
    tick();
    chk("unk_wrap_result", aluResult, 32'd1);

    // detailed mul timing
    issue(4'b0010, 32'h0001_0003, 32'h0000_0005);
    #1;
    chk("mul_issue_stall", {31'b0, stall}, 32'd1);
    tick();
    idle_in();
    for (int i = 0; i < 32; i++) begin
      chk("mul_busy_ready", {31'b0, in_ready}, 32'd0);
      chk("mul_busy_stall", {31'b0, stall}, 32'd1);
      chk("mul_busy_valid", {31'b0, out_valid}, 32'd0);
      tick();
    end
    chk("mul_done_valid", {31'b0, out_valid}, 32'd1);
    chk("mul_done_result", aluResult, 32'h0005_000F);
    chk("mul_done_ready", {31'b0, in_ready}, 32'd1);
    chk("mul_done_stall", {31'b0, stall}, 32'd0);
    tick();
    chk("mul_after_valid", {31'b0, out_valid}, 32'd0);

    mul_expect("mul_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    mul_expect("mul_msb", 32'h8000_0000, 32'd2, 32'h0);
    mul_expect("mul_zero", 32'h0000_1234, 32'd0, 32'h0);
    mul_expect("mul_nine", 32'h1234_5678, 32'd9, 32'hA3D7_0A38);

    // flush during mul cycle 10
    issue(4'b0010, 32'd3, 32'd3);
    tick();
    idle_in();
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_ready", {31'b0, in_ready}, 32'd1);
    chk("flush_stall", {31'b0, stall}, 32'd0);
    issue(4'b0000, 32'd1, 32'd1);
    tick();
    chk("flush_add_valid", {31'b0, out_valid}, 32'd1);
    chk("flush_add_result", aluResult, 32'd2);
    idle_in();
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) pulses++;
    end
    chk("flush_no_late_pulse", pulses, 32'd0);

    // flush in IDLE drops the op presented alongside it
    issue(4'b0000, 32'd5, 32'd5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle_in();
    chk("flush_idle_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_idle_hold", aluResult, 32'd2);

    // reset mid-mul with in_valid asserted
    issue(4'b0010, 32'd7, 32'd6);
    tick();
    idle_in();
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    issue(4'b0000, 32'd1, 32'd2);
    tick();
    chk("rstmid_valid", {31'b0, out_valid}, 32'd0);
    chk("rstmid_result", aluResult, 32'h0);
    chk("rstmid_zero", {31'b0, zero}, 32'd1);
    chk("rstmid_ready", {31'b0, in_ready}, 32'd0);
    chk("rstmid_stall", {31'b0, stall}, 32'd0);
    rst = 1'b0;
    idle_in();
    tick();
    chk("rstmid_after_valid", {31'b0, out_valid}, 32'd0);
    chk("rstmid_after_result", aluResult, 32'h0);
    chk("rstmid_after_ready", {31'b0, in_ready}, 32'd1);
    mul_expect("mul_after_rst", 32'd7, 32'd6, 32'd42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
